mem_dump_ctrl: RTL and testbench

MEM_DUMP_CTRL -- requirements
Module: mem_dump_ctrl

---
 rtl/mem_dump_pkg.sv | 17 +
 rtl/dump_skid_fifo.sv | 58 +++++
 rtl/mem_dump_ctrl.sv | 153 +++++++++++++++
 tb/tb_mem_dump_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dump_pkg.sv
// Shared types for the memory dump controller: FSM states and trigger causes.
package mem_dump_pkg;

    typedef enum logic [1:0] {
        ST_ARMED = 2'd0,
        ST_DUMP  = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_START   = 2'b01,
        CAUSE_HALT    = 2'b10,
        CAUSE_TIMEOUT = 2'b11
    } cause_e;

endpackage

// File: rtl/dump_skid_fifo.sv
// Two-entry output buffer with same-cycle bypass when empty.
module dump_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] data,
    output logic [1:0]   level
);

    logic [W-1:0] mem_q [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   cnt;
    logic         empty;
    logic         do_wr;
    logic         do_rd;

    assign empty = (cnt == 2'd0);
    assign valid = !empty || push;
    assign data  = empty ? push_data : mem_q[rd_ptr];
    assign level = cnt;

    // A word that arrives into an empty buffer and is taken at once is never stored.
    assign do_wr = push && !(empty && pop);
    assign do_rd = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_wr) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_rd) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mem_dump_ctrl.sv
// Triggered memory dump: reads a fixed address window and streams it out
// over a valid/ready interface with at most two words outstanding.
module mem_dump_ctrl
    import mem_dump_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int COUNT     = 1023,
    parameter int TIMEOUT   = 1120
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt,
    input  logic              rearm,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [1:0]        trig_cause
);

    localparam int PW = DATA_W + ADDR_W + 1;
    localparam int CW = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BASE_ADDR + COUNT - 1);
    localparam logic [CW-1:0] NWORDS = CW'(COUNT);

    state_e            state_q;
    state_e            state_d;
    cause_e            cause_q;
    cause_e            cause_d;
    logic              trig;
    logic              tmo_hit;
    logic              rd_go;
    logic [31:0]       tmo_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [CW-1:0]     rd_cnt_q;
    logic              pend_q;
    logic [ADDR_W-1:0] pend_addr_q;
    logic              pop;
    logic              f_valid;
    logic [PW-1:0]     f_data;
    logic [PW-1:0]     push_data;
    logic [1:0]        level;

    assign tmo_hit = (TIMEOUT > 0) && (tmo_q == 32'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        cause_d = CAUSE_NONE;
        trig    = 1'b0;
        rd_go   = 1'b0;
        unique case (state_q)
            ST_ARMED: begin
                trig = start || halt || tmo_hit;
                if (start) begin
                    cause_d = CAUSE_START;
                end else if (halt) begin
                    cause_d = CAUSE_HALT;
                end else begin
                    cause_d = CAUSE_TIMEOUT;
                end
                if (trig) begin
                    state_d = ST_DUMP;
                end
            end
            ST_DUMP: begin
                // Credit: in-flight read plus buffered words must stay below two.
                rd_go = (rd_cnt_q < NWORDS) && ((level + {1'b0, pend_q}) < 2'd2);
                if (pop && f_data[0]) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rearm) begin
                    state_d = ST_ARMED;
                end
            end
            default: state_d = ST_ARMED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ARMED;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cause_q     <= CAUSE_NONE;
            tmo_q       <= 32'd0;
            rd_addr_q   <= BASE;
            rd_cnt_q    <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= BASE;
        end else begin
            pend_q <= rd_go;
            if (rd_go) begin
                pend_addr_q <= rd_addr_q;
                rd_addr_q   <= rd_addr_q + ADDR_W'(1);
                rd_cnt_q    <= rd_cnt_q + CW'(1);
            end
            if (trig) begin
                cause_q   <= cause_d;
                rd_addr_q <= BASE;
                rd_cnt_q  <= '0;
            end
            if (state_q == ST_ARMED && !trig) begin
                tmo_q <= tmo_q + 32'd1;
            end else begin
                tmo_q <= 32'd0;
            end
        end
    end

    assign push_data = {mem_rd_data, pend_addr_q, pend_addr_q == LAST};
    assign pop       = f_valid && out_ready;

    dump_skid_fifo #(
        .W(PW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (pend_q),
        .push_data(push_data),
        .pop      (pop),
        .valid    (f_valid),
        .data     (f_data),
        .level    (level)
    );

    assign mem_rd_en   = rd_go;
    assign mem_rd_addr = rd_addr_q;
    assign out_valid   = f_valid;
    assign out_data    = f_valid ? f_data[PW-1 -: DATA_W] : '0;
    assign out_addr    = f_valid ? f_data[ADDR_W:1] : BASE;
    assign out_last    = f_valid && f_data[0];
    assign busy        = (state_q == ST_DUMP);
    assign done        = (state_q == ST_DONE);
    assign trig_cause  = cause_q;

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Self-checking bench for mem_dump_ctrl using three differently sized
// instances against a word-list reference model and a random memory image.
module tb_mem_dump_ctrl;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int BA = 8;
    localparam int BB = 16;
    localparam int NB = 8;
    localparam int BC = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic [DW-1:0] mem [1024];

    logic a_start = 0, a_halt = 0, a_rearm = 0, a_ready = 1;
    logic a_rd_en, a_valid, a_last, a_busy, a_done;
    logic [AW-1:0] a_rd_addr, a_addr;
    logic [DW-1:0] a_rd_data, a_data;
    logic [1:0] a_cause;

    logic b_start = 0, b_halt = 0, b_rearm = 0, b_ready = 1;
    logic b_rd_en, b_valid, b_last, b_busy, b_done;
    logic [AW-1:0] b_rd_addr, b_addr;
    logic [DW-1:0] b_rd_data, b_data;
    logic [1:0] b_cause;

    logic c_start = 0, c_halt = 0, c_rearm = 0, c_ready = 1;
    logic c_rd_en, c_valid, c_last, c_busy, c_done;
    logic [AW-1:0] c_rd_addr, c_addr;
    logic [DW-1:0] c_rd_data, c_data;
    logic [1:0] c_cause;

    // Memory model: data valid one cycle after the strobe, garbage otherwise.
    always @(posedge clk) a_rd_data <= a_rd_en ? mem[a_rd_addr] : $urandom;
    always @(posedge clk) b_rd_data <= b_rd_en ? mem[b_rd_addr] : $urandom;
    always @(posedge clk) c_rd_data <= c_rd_en ? mem[c_rd_addr] : $urandom;

    mem_dump_ctrl #(.DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(BA), .COUNT(4), .TIMEOUT(0)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .halt(a_halt), .rearm(a_rearm),
        .mem_rd_en(a_rd_en), .mem_rd_addr(a_rd_addr), .mem_rd_data(a_rd_data),
        .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data), .out_addr(a_addr),
        .out_last(a_last), .busy(a_busy), .done(a_done), .trig_cause(a_cause));

    mem_dump_ctrl #(.DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(BB), .COUNT(NB), .TIMEOUT(0)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .halt(b_halt), .rearm(b_rearm),
        .mem_rd_en(b_rd_en), .mem_rd_addr(b_rd_addr), .mem_rd_data(b_rd_data),
        .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data), .out_addr(b_addr),
        .out_last(b_last), .busy(b_busy), .done(b_done), .trig_cause(b_cause));

    mem_dump_ctrl #(.DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(BC), .COUNT(1), .TIMEOUT(20)) u_c (
        .clk(clk), .rst(rst), .start(c_start), .halt(c_halt), .rearm(c_rearm),
        .mem_rd_en(c_rd_en), .mem_rd_addr(c_rd_addr), .mem_rd_data(c_rd_data),
        .out_valid(c_valid), .out_ready(c_ready), .out_data(c_data), .out_addr(c_addr),
        .out_last(c_last), .busy(c_busy), .done(c_done), .trig_cause(c_cause));

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({b_rd_en, b_valid, b_last, b_busy, b_done} !== 5'b0)
            $display("FAIL rst_flags got %b exp 00000", {b_rd_en, b_valid, b_last, b_busy, b_done});
        else passed++;
        checks++;
        if ({b_cause, b_data} !== {2'b00, 32'h0})
            $display("FAIL rst_cause_data got %0h/%0h exp 0/0", b_cause, b_data);
        else passed++;
        checks++;
        if ({b_rd_addr, b_addr, a_rd_addr} !== {AW'(BB), AW'(BB), AW'(BA)})
            $display("FAIL rst_addr got %0d/%0d/%0d exp %0d/%0d/%0d",
                     b_rd_addr, b_addr, a_rd_addr, BB, BB, BA);
        else passed++;
        drive_edge();
        rst = 1'b0;
    endtask

    // Instance c was armed by the reset release; cycle 0 is the first armed cycle.
    task automatic test_timeout();
        int first_busy = -1;
        logic [1:0] cause_seen = 2'b00;
        logic [AW-1:0] addr_seen = '0;
        logic [DW+1:0] word_seen = '0;
        for (int k = 0; k <= 25; k++) begin
            @(negedge clk);
            if (c_busy && first_busy < 0) begin
                first_busy = k;
                cause_seen = c_cause;
                addr_seen = c_rd_addr;
            end
            if (c_valid) word_seen = {c_valid, c_last, c_data};
        end
        checks++;
        if (first_busy !== 20) $display("FAIL tmo_cycle got %0d exp 20", first_busy);
        else passed++;
        checks++;
        if (cause_seen !== 2'b11) $display("FAIL tmo_cause got %b exp 11", cause_seen);
        else passed++;
        checks++;
        if (addr_seen !== AW'(BC)) $display("FAIL tmo_addr got %0d exp %0d", addr_seen, BC);
        else passed++;
        checks++;
        if (word_seen !== {2'b11, mem[BC]})
            $display("FAIL tmo_word got %0h exp %0h", word_seen, {2'b11, mem[BC]});
        else passed++;
        checks++;
        if (c_done !== 1'b1) $display("FAIL tmo_done got %b exp 1", c_done);
        else passed++;
    endtask

    task automatic test_count1();
        int words = 0;
        drive_edge();
        c_rearm = 1;
        drive_edge();
        c_rearm = 0;
        @(negedge clk);
        checks++;
        if ({c_done, c_busy} !== 2'b00) $display("FAIL c1_rearm got %b exp 00", {c_done, c_busy});
        else passed++;
        drive_edge();
        c_start = 1;
        drive_edge();
        c_start = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (c_valid) begin
                words++;
                checks++;
                if ({c_last, c_addr, c_data} !== {1'b1, AW'(BC), mem[BC]} || k !== 2)
                    $display("FAIL c1_word got k%0d %b/%0d/%0h exp k2 1/%0d/%0h",
                             k, c_last, c_addr, c_data, BC, mem[BC]);
                else passed++;
            end
            if (k == 3) begin
                checks++;
                if ({c_done, c_busy, c_rd_en} !== 3'b100)
                    $display("FAIL c1_done got %b exp 100", {c_done, c_busy, c_rd_en});
                else passed++;
            end
            drive_edge();
        end
        checks++;
        if (words !== 1) $display("FAIL c1_count got %0d exp 1", words);
        else passed++;
    endtask

    task automatic test_basic();
        logic [AW+DW:0] got, exp;
        a_ready = 1;
        drive_edge();
        a_start = 1;
        drive_edge();
        a_start = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if ({a_busy, a_rd_en, a_valid, a_rd_addr} !== {3'b110, AW'(BA)})
                    $display("FAIL basic_first got %b/%0d exp 110/%0d",
                             {a_busy, a_rd_en, a_valid}, a_rd_addr, BA);
                else passed++;
            end else if (k <= 5) begin
                got = {a_valid, a_addr, a_data, a_last};
                exp = {1'b1, AW'(BA + k - 2), mem[BA + k - 2], k == 5};
                checks++;
                if (got !== exp) $display("FAIL basic_word%0d got %0h exp %0h", k - 2, got, exp);
                else passed++;
            end else begin
                checks++;
                if ({a_done, a_busy, a_valid, a_cause} !== 5'b10001)
                    $display("FAIL basic_done got %b exp 10001", {a_done, a_busy, a_valid, a_cause});
                else passed++;
            end
            drive_edge();
        end
    endtask

    task automatic test_cause();
        drive_edge();
        a_rearm = 1;
        drive_edge();
        a_rearm = 0;
        @(negedge clk);
        checks++;
        if ({a_done, a_cause} !== 3'b001) $display("FAIL cause_rearm got %b exp 001", {a_done, a_cause});
        else passed++;
        drive_edge();
        a_start = 1;
        a_halt = 1;
        drive_edge();
        a_start = 0;
        a_halt = 0;
        @(negedge clk);
        checks++;
        if ({a_busy, a_cause} !== 3'b101) $display("FAIL cause_both got %b exp 101", {a_busy, a_cause});
        else passed++;
        for (int i = 0; i < 30 && !a_done; i++) @(negedge clk);
        drive_edge();
        a_rearm = 1;
        drive_edge();
        a_rearm = 0;
        a_halt = 1;
        drive_edge();
        @(negedge clk);
        checks++;
        if ({a_busy, a_cause} !== 3'b110) $display("FAIL cause_halt got %b exp 110", {a_busy, a_cause});
        else passed++;
        for (int i = 0; i < 30 && !a_done; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if ({a_done, a_busy, a_cause} !== 4'b1010)
            $display("FAIL cause_hold got %b exp 1010", {a_done, a_busy, a_cause});
        else passed++;
        drive_edge();
        a_halt = 0;
    endtask

    // mode 0: ready 1,0,0,1 repeating; 1: random ready; 2: ready always high.
    task automatic test_stream(input int mode, input string name);
        logic [AW+DW:0] exp_q [$];
        logic [AW+DW:0] got, held;
        logic stalled = 0;
        int got_n = 0;
        for (int i = 0; i < NB; i++) exp_q.push_back({AW'(BB + i), mem[BB + i], i == NB - 1});
        if (b_done) begin
            drive_edge();
            b_rearm = 1;
            drive_edge();
            b_rearm = 0;
        end
        drive_edge();
        b_start = 1;
        drive_edge();
        b_start = 0;
        for (int cyc = 1; cyc < 150 && !b_done; cyc++) begin
            case (mode)
                0: b_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                1: b_ready = 1'($urandom_range(0, 1));
                default: b_ready = 1;
            endcase
            @(negedge clk);
            got = {b_addr, b_data, b_last};
            if (stalled) begin
                checks++;
                if (!b_valid || got !== held)
                    $display("FAIL %s_hold got %b/%0h exp 1/%0h", name, b_valid, got, held);
                else passed++;
            end
            if (b_valid && b_ready) begin
                checks++;
                if (exp_q.size() == 0) $display("FAIL %s_extra got %0h exp none", name, got);
                else if (got !== exp_q[0]) $display("FAIL %s_word got %0h exp %0h", name, got, exp_q[0]);
                else passed++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                got_n++;
            end
            stalled = b_valid && !b_ready;
            held = got;
            drive_edge();
        end
        b_ready = 1;
        checks++;
        if (got_n !== NB || b_done !== 1'b1)
            $display("FAIL %s_count got %0d/%b exp %0d/1", name, got_n, b_done, NB);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int got_n = 0;
        if (b_done) begin
            drive_edge();
            b_rearm = 1;
            drive_edge();
            b_rearm = 0;
        end
        b_ready = 1;
        drive_edge();
        b_start = 1;
        drive_edge();
        b_start = 0;
        for (int cyc = 0; cyc < 20 && got_n < 3; cyc++) begin
            @(negedge clk);
            if (b_valid && b_ready) got_n++;
            drive_edge();
        end
        rst = 1;
        #1;
        checks++;
        if ({b_rd_en, b_valid, b_last, b_busy, b_done, b_cause} !== 7'b0 || b_data !== '0)
            $display("FAIL midrst_flags got %b/%0h exp 0/0",
                     {b_rd_en, b_valid, b_last, b_busy, b_done, b_cause}, b_data);
        else passed++;
        checks++;
        if ({b_rd_addr, b_addr} !== {AW'(BB), AW'(BB)})
            $display("FAIL midrst_addr got %0d/%0d exp %0d/%0d", b_rd_addr, b_addr, BB, BB);
        else passed++;
        drive_edge();
        rst = 0;
        @(negedge clk);
        checks++;
        if ({b_busy, b_valid, b_done} !== 3'b000)
            $display("FAIL midrst_armed got %b exp 000", {b_busy, b_valid, b_done});
        else passed++;
        test_stream(2, "post_rst");
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        test_reset();
        test_timeout();
        test_count1();
        test_basic();
        test_cause();
        test_stream(0, "stall");
        test_stream(1, "random");
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
